// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
//
// Duration timer for the traffic-light controller. It decodes the
// controller's one-hot phase indication, counts the configured number of
// seconds for the active phase and returns a single-cycle end pulse for that
// phase when its time runs out. The remaining seconds are exported in binary
// and as two BCD digits for the countdown display.
//
// Parameters
//   TICK_DIV : clk cycles per one-second tick (>= 2)
//   G_TIME   : green duration in seconds   (clipped to 1..99)
//   Y_TIME   : yellow duration in seconds  (clipped to 1..99)
//   R_TIME   : all-red duration in seconds (clipped to 1..99)
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst_n        in   synchronous, active-low reset
//   fsm_g        in   controller is in a green phase
//   fsm_y        in   controller is in a yellow phase
//   fsm_r        in   controller is in an all-red phase
//   hold         in   freeze prescaler and countdown while high
//   g_end        out  one-cycle pulse, green time expired
//   y_end        out  one-cycle pulse, yellow time expired
//   r_end        out  one-cycle pulse, red time expired
//   remain       out  seconds remaining in current phase, 0..99
//   remain_tens  out  BCD tens digit of remain
//   remain_ones  out  BCD ones digit of remain
// ---------------------------------------------------------------------------
module phase_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int G_TIME   = 25,
  parameter int Y_TIME   = 3,
  parameter int R_TIME   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fsm_g,
  input  logic       fsm_y,
  input  logic       fsm_r,
  input  logic       hold,
  output logic       g_end,
  output logic       y_end,
  output logic       r_end,
  output logic [6:0] remain,
  output logic [3:0] remain_tens,
  output logic [3:0] remain_ones
);

  // Prescaler width; TICK_DIV >= 2 keeps this at least one bit.
  localparam int PW = $clog2(TICK_DIV);

  // Decoded phase encoding.
  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_G    = 2'd1;
  localparam logic [1:0] PH_Y    = 2'd2;
  localparam logic [1:0] PH_R    = 2'd3;

  // Timer states.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Saturate a configured duration into the displayable 1..99 range.
  function automatic logic [6:0] clip_dur(input int d);
    if (d < 1) begin
      return 7'd1;
    end else if (d > 99) begin
      return 7'd99;
    end else begin
      return 7'(d);
    end
  endfunction

  // Binary 0..99 to two BCD digits by repeated compare/subtract of ten.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

  localparam logic [6:0] G_DUR = clip_dur(G_TIME);
  localparam logic [6:0] Y_DUR = clip_dur(Y_TIME);
  localparam logic [6:0] R_DUR = clip_dur(R_TIME);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  function automatic logic [6:0] dur_of(input logic [1:0] ph);
    case (ph)
      PH_G:    return G_DUR;
      PH_Y:    return Y_DUR;
      PH_R:    return R_DUR;
      default: return 7'd0;
    endcase
  endfunction

  logic [1:0]    phase;
  logic [1:0]    prev_phase;
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nx;
  logic [6:0]    remain_nx;
  logic          g_end_nx;
  logic          y_end_nx;
  logic          r_end_nx;
  logic          entry;
  logic          tick;

  // Phase decode: exactly one indication high selects a phase; anything else
  // (none, or an illegal overlap) is treated as NONE.
  always_comb begin
    case ({fsm_g, fsm_y, fsm_r})
      3'b100:  phase = PH_G;
      3'b010:  phase = PH_Y;
      3'b001:  phase = PH_R;
      default: phase = PH_NONE;
    endcase
  end

  assign entry = (phase != PH_NONE) && (phase != prev_phase);
  assign tick  = (state == COUNT) && !hold && (presc == PRESC_LAST);

  // Next-state logic. NONE wins over everything, then phase entry, so a
  // phase change mid-count reloads without ever pulsing the abandoned phase.
  always_comb begin
    state_nx  = state;
    presc_nx  = presc;
    remain_nx = remain;
    g_end_nx  = 1'b0;
    y_end_nx  = 1'b0;
    r_end_nx  = 1'b0;

    if (phase == PH_NONE) begin
      state_nx  = IDLE;
      presc_nx  = '0;
      remain_nx = 7'd0;
    end else if (entry) begin
      state_nx  = COUNT;
      presc_nx  = '0;
      remain_nx = dur_of(phase);
    end else if ((state == COUNT) && !hold) begin
      if (tick) begin
        presc_nx = '0;
        if (remain > 7'd1) begin
          remain_nx = remain - 7'd1;
        end else begin
          // Last second elapsed: pulse for the phase that is still active.
          remain_nx = 7'd0;
          state_nx  = DONE;
          case (phase)
            PH_G:    g_end_nx = 1'b1;
            PH_Y:    y_end_nx = 1'b1;
            PH_R:    r_end_nx = 1'b1;
            default: ;
          endcase
        end
      end else begin
        presc_nx = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_phase <= PH_NONE;
      presc      <= '0;
      remain     <= 7'd0;
      g_end      <= 1'b0;
      y_end      <= 1'b0;
      r_end      <= 1'b0;
    end else begin
      state      <= state_nx;
      prev_phase <= phase;
      presc      <= presc_nx;
      remain     <= remain_nx;
      g_end      <= g_end_nx;
      y_end      <= y_end_nx;
      r_end      <= r_end_nx;
    end
  end

  // Display digits follow remain combinationally.
  always_comb begin
    {remain_tens, remain_ones} = to_bcd(remain);
  end

endmodule

// File: tb/tb_phase_timer.sv
module tb_phase_timer;

  localparam int TD = 4;
  localparam int GT = 3;
  localparam int YT = 2;
  localparam int RT = 1;

  logic       clk;
  logic       rst_n;
  logic       fsm_g;
  logic       fsm_y;
  logic       fsm_r;
  logic       hold;
  logic       g_end;
  logic       y_end;
  logic       r_end;
  logic [6:0] remain;
  logic [3:0] remain_tens;
  logic [3:0] remain_ones;

  phase_timer #(
    .TICK_DIV(TD),
    .G_TIME  (GT),
    .Y_TIME  (YT),
    .R_TIME  (RT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fsm_g      (fsm_g),
    .fsm_y      (fsm_y),
    .fsm_r      (fsm_r),
    .hold       (hold),
    .g_end      (g_end),
    .y_end      (y_end),
    .r_end      (r_end),
    .remain     (remain),
    .remain_tens(remain_tens),
    .remain_ones(remain_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: tracks how many un-held counting cycles have elapsed
  // since the current phase was entered and derives the display from that.
  int cyc;
  int m_prev;
  bit m_act;
  int m_el;
  int m_dur;
  int e_rem;
  bit e_g, e_y, e_r;

  // Pulse bookkeeping per scenario.
  int g_cnt, y_cnt, r_cnt;
  int g_at, y_at, r_at;

  function automatic int clip(input int d);
    if (d < 1) return 1;
    if (d > 99) return 99;
    return d;
  endfunction

  function automatic int decode(input logic [2:0] gyr);
    case (gyr)
      3'b100:  return 1;
      3'b010:  return 2;
      3'b001:  return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int dur_for(input int ph);
    case (ph)
      1:       return clip(GT);
      2:       return clip(YT);
      default: return clip(RT);
    endcase
  endfunction

  task automatic model_step();
    int ph;
    e_g = 1'b0;
    e_y = 1'b0;
    e_r = 1'b0;
    if (!rst_n) begin
      m_prev = 0;
      m_act  = 1'b0;
      e_rem  = 0;
    end else begin
      ph = decode({fsm_g, fsm_y, fsm_r});
      if (ph == 0) begin
        m_act = 1'b0;
        e_rem = 0;
      end else if (ph != m_prev) begin
        m_dur = dur_for(ph);
        m_el  = 0;
        m_act = 1'b1;
        e_rem = m_dur;
      end else if (m_act && !hold) begin
        m_el++;
        if (m_el == m_dur * TD) begin
          m_act = 1'b0;
          e_rem = 0;
          e_g   = (ph == 1);
          e_y   = (ph == 2);
          e_r   = (ph == 3);
        end else begin
          e_rem = m_dur - m_el / TD;
        end
      end
      m_prev = ph;
    end
  endtask

  task automatic clr_counts();
    g_cnt = 0; y_cnt = 0; r_cnt = 0;
    g_at = -1; y_at = -1; r_at = -1;
  endtask

  // Drive one cycle's inputs, let the edge happen, then compare every output
  // against the model shortly after the edge.
  task automatic step(input bit rn, input logic [2:0] gyr, input bit h);
    rst_n = rn;
    fsm_g = gyr[2];
    fsm_y = gyr[1];
    fsm_r = gyr[0];
    hold  = h;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("remain", int'(remain), e_rem);
    chk("tens", int'(remain_tens), e_rem / 10);
    chk("ones", int'(remain_ones), e_rem % 10);
    chk("g_end", int'(g_end), int'(e_g));
    chk("y_end", int'(y_end), int'(e_y));
    chk("r_end", int'(r_end), int'(e_r));
    if (g_end) begin g_cnt++; g_at = cyc; end
    if (y_end) begin y_cnt++; y_at = cyc; end
    if (r_end) begin r_cnt++; r_at = cyc; end
    @(negedge clk);
  endtask

  localparam logic [2:0] G  = 3'b100;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] R  = 3'b001;
  localparam logic [2:0] GY = 3'b110;

  initial begin
    int n;
    logic [2:0] pat;
    rst_n = 1'b0; fsm_g = 1'b0; fsm_y = 1'b0; fsm_r = 1'b0; hold = 1'b0;
    cyc = 0; m_prev = 0; m_act = 1'b0; m_el = 0; m_dur = 0; e_rem = 0;
    e_g = 1'b0; e_y = 1'b0; e_r = 1'b0;
    clr_counts();

    // Reset state.
    repeat (3) step(1'b0, R, 1'b0);
    chk("rst_remain", int'(remain), 0);
    chk("rst_pulses", int'(g_end) + int'(y_end) + int'(r_end), 0);

    // Release with all-red from cycle 0.
    cyc = 0;
    clr_counts();
    step(1'b1, R, 1'b0);
    chk("r_load", int'(remain), 1);
    repeat (7) step(1'b1, R, 1'b0);
    chk("r_end_at", r_at, 5);
    chk("r_end_cnt", r_cnt, 1);
    chk("gy_quiet", g_cnt + y_cnt, 0);

    // Green countdown with BCD display.
    clr_counts();
    n = cyc;
    step(1'b1, G, 1'b0);
    chk("g_load", int'(remain), 3);
    chk("g_tens", int'(remain_tens), 0);
    chk("g_ones", int'(remain_ones), 3);
    repeat (15) step(1'b1, G, 1'b0);
    chk("g_end_at", g_at, n + 13);
    chk("g_end_cnt", g_cnt, 1);

    // Stay in green after expiry: silent, remain stays 0.
    repeat (40) step(1'b1, G, 1'b0);
    chk("g_done_cnt", g_cnt, 1);
    chk("g_done_rem", int'(remain), 0);

    // Yellow after green expiry.
    clr_counts();
    n = cyc;
    step(1'b1, Y, 1'b0);
    chk("y_load", int'(remain), 2);
    repeat (10) step(1'b1, Y, 1'b0);
    chk("y_end_at", y_at, n + 9);
    chk("y_end_cnt", y_cnt, 1);

    // Green with hold for 5 cycles mid-count.
    clr_counts();
    n = cyc;
    for (int i = 0; i < 20; i++) step(1'b1, G, (i >= 3 && i < 8));
    chk("hold_g_at", g_at, n + 18);
    chk("hold_g_cnt", g_cnt, 1);

    // Overlapping indications collapse to NONE; yellow alone reloads.
    clr_counts();
    repeat (4) step(1'b1, Y, 1'b0);
    step(1'b1, GY, 1'b0);
    chk("gy_rem", int'(remain), 0);
    step(1'b1, Y, 1'b0);
    chk("gy_reload", int'(remain), 2);
    chk("gy_pulses", g_cnt + y_cnt + r_cnt, 0);

    // Green abandoned for yellow at N+6.
    clr_counts();
    n = cyc;
    repeat (6) step(1'b1, G, 1'b0);
    step(1'b1, Y, 1'b0);
    chk("gy_sw_rem", int'(remain), 2);
    repeat (12) step(1'b1, Y, 1'b0);
    chk("gy_sw_g_cnt", g_cnt, 0);
    chk("gy_sw_y_at", y_at, n + 15);

    // Reset asserted at N+3 of a green phase.
    clr_counts();
    n = cyc;
    repeat (3) step(1'b1, G, 1'b0);
    step(1'b0, G, 1'b0);
    chk("mid_rst_cyc", cyc, n + 4);
    chk("mid_rst_rem", int'(remain), 0);
    chk("mid_rst_bcd", int'(remain_tens) + int'(remain_ones), 0);
    chk("mid_rst_pulse", int'(g_end) + int'(y_end) + int'(r_end), 0);
    step(1'b1, G, 1'b0);
    chk("post_rst_load", int'(remain), 3);

    // Randomized phase sequences, holds and occasional resets.
    for (int s = 0; s < 150; s++) begin
      case ($urandom % 10)
        0, 1, 2: pat = G;
        3, 4, 5: pat = Y;
        6, 7, 8: pat = R;
        default: pat = 3'($urandom % 8);
      endcase
      n = int'($urandom_range(1, 40));
      for (int k = 0; k < n; k++)
        step(($urandom % 150) != 0, pat, ($urandom % 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
